// File: rtl/softmax_pkg.sv
// Shared types and constants for the Softmax front stage.
package softmax_pkg;

  // Default signed element width on the input side.
  localparam int unsigned DefaultDataWidth = 8;

  // Front-stage control states: collect a vector, then replay it.
  typedef enum logic [0:0] {
    StLoad,
    StReplay
  } state_e;

  // (x - max) of two DW-bit signed values needs one extra bit.
  function automatic int unsigned diff_width(input int unsigned dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/softmax_vec_buf.sv
// Vector buffer: Depth x Width register file, one sync write, one async read.
// Contents are not reset; every replayed entry is written before it is read.
module softmax_vec_buf
  import softmax_pkg::*;
#(
  parameter int unsigned Width = DefaultDataWidth,
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Synchronous write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/softmax_max_sub.sv
// Softmax front stage: buffers one score vector, tracks its signed maximum while
// loading, then replays every element as (x - max) so the exponent unit downstream
// only ever sees non-positive operands.
module softmax_max_sub
  import softmax_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned VEC_LEN    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH:0]   out_data,
  output logic signed [DATA_WIDTH-1:0] out_max,
  output logic                         out_last
);

  localparam int unsigned CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int unsigned DiffW = diff_width(DATA_WIDTH);

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]              rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]              last_idx_q, last_idx_d;
  logic signed [DATA_WIDTH-1:0]  run_max_q, run_max_d;
  logic signed [DATA_WIDTH-1:0]  out_max_q, out_max_d;
  logic                          out_valid_q, out_valid_d;
  logic signed [DiffW-1:0]       out_data_q, out_data_d;
  logic                          out_last_q, out_last_d;

  logic                          wr_en;
  logic [CNT_W-1:0]              rd_addr;
  logic [CNT_W-1:0]              rd_next;
  logic signed [DATA_WIDTH-1:0]  rd_data;
  logic signed [DATA_WIDTH-1:0]  max_new;
  logic signed [DATA_WIDTH-1:0]  first_elem;
  logic                          close_vec;

  // Sign-extend both operands before subtracting so the result cannot wrap.
  function automatic logic signed [DiffW-1:0] sub_max(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic signed [DATA_WIDTH-1:0] m
  );
    logic signed [DiffW-1:0] xe;
    logic signed [DiffW-1:0] me;
    xe = DiffW'(x);
    me = DiffW'(m);
    return xe - me;
  endfunction

  softmax_vec_buf #(
    .Width(DATA_WIDTH),
    .Depth(VEC_LEN),
    .AddrW(CNT_W)
  ) u_vec_buf (
    .clk_i  (clk),
    .we_i   (wr_en),
    .waddr_i(wr_cnt_q),
    .wdata_i(in_data),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  assign in_ready  = (state_q == StLoad);
  assign rd_next   = rd_cnt_q + CNT_W'(1);
  // In LOAD the read port looks at entry 0 so the first replay beat is ready at close.
  assign rd_addr   = (state_q == StReplay) ? rd_next : '0;
  // First beat seeds the running max; ties keep the current value.
  assign max_new   = ((wr_cnt_q == '0) || (in_data > run_max_q)) ? in_data : run_max_q;
  // For a one-element vector entry 0 is being written this cycle, so bypass it.
  assign first_elem = (wr_cnt_q == '0) ? in_data : rd_data;
  assign close_vec = in_last || (wr_cnt_q == CNT_W'(VEC_LEN - 1));

  // Next-state logic: load/compare in LOAD, registered subtract-and-replay in REPLAY.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    last_idx_d  = last_idx_q;
    run_max_d   = run_max_q;
    out_max_d   = out_max_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    wr_en       = 1'b0;

    case (state_q)
      StLoad: begin
        if (in_valid) begin
          wr_en     = 1'b1;
          run_max_d = max_new;
          wr_cnt_d  = wr_cnt_q + CNT_W'(1);
          if (close_vec) begin
            state_d     = StReplay;
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
            last_idx_d  = wr_cnt_q;
            out_max_d   = max_new;
            out_valid_d = 1'b1;
            out_data_d  = sub_max(first_elem, max_new);
            out_last_d  = (wr_cnt_q == '0);
          end
        end
      end
      StReplay: begin
        // out_valid is always high here, so out_ready alone completes a beat.
        if (out_ready) begin
          if (rd_cnt_q == last_idx_q) begin
            state_d     = StLoad;
            rd_cnt_d    = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
          end else begin
            rd_cnt_d   = rd_next;
            out_data_d = sub_max(rd_data, out_max_q);
            out_last_d = (rd_next == last_idx_q);
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // State and output registers; the buffer itself is not reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StLoad;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      last_idx_q  <= '0;
      run_max_q   <= '0;
      out_max_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      last_idx_q  <= last_idx_d;
      run_max_q   <= run_max_d;
      out_max_q   <= out_max_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_max   = out_max_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_softmax_max_sub.sv
// Self-checking bench for softmax_max_sub with an expected-result queue.
module tb_softmax_max_sub;

  localparam int DW = 8;
  localparam int VL = 16;

  typedef struct {
    logic signed [DW:0]   data;
    logic                 last;
    logic signed [DW-1:0] max;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_last = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [DW:0]   out_data;
  logic signed [DW-1:0] out_max;
  logic                 out_last;

  int   checks = 0;
  int   failures = 0;
  int   vec [VL];
  exp_t exp_q[$];

  softmax_max_sub #(
    .DATA_WIDTH(DW),
    .VEC_LEN   (VL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_max  (out_max),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  // Drive vec[0..n-1] one beat per cycle and queue the expected replay.
  task automatic send_vector(input int n, input bit use_last);
    int mx;
    exp_t e;
    mx = vec[0];
    for (int i = 1; i < n; i++) if (vec[i] > mx) mx = vec[i];
    for (int i = 0; i < n; i++) begin
      e.data = (DW+1)'(vec[i] - mx);
      e.last = (i == n - 1);
      e.max  = DW'(mx);
      exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DW'(vec[i]);
      in_last  = use_last && (i == n - 1);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL in_ready_load beat %0d: got %b want 1", i, in_ready);
      end
    end
    @(posedge clk);
  endtask

  // Collect replay beats and compare against the queue; stop after stop_after beats.
  task automatic drain(input int n, input bit rand_ready, input bit junk, input int stop_after,
                       output int lo_cnt);
    int   got;
    int   budget;
    bit   held;
    logic signed [DW:0]   h_data;
    logic                 h_last;
    logic signed [DW-1:0] h_max;
    exp_t e;
    got = 0;
    lo_cnt = 0;
    held = 1'b0;
    budget = n * 20 + 20;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      in_valid  = junk;
      in_data   = junk ? DW'($urandom) : '0;
      in_last   = junk;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!in_ready) lo_cnt++;
      if (cyc == 0) begin
        checks++;
        if (out_valid !== 1'b1) begin
          failures++;
          $display("FAIL first_out_latency: out_valid got %b want 1", out_valid);
        end
      end
      if (held && out_valid) begin
        checks++;
        if (out_data !== h_data || out_last !== h_last || out_max !== h_max) begin
          failures++;
          $display("FAIL stall_stable: got %0d/%b/%0d want %0d/%b/%0d", out_data, out_last,
                   out_max, h_data, h_last, h_max);
        end
      end
      held = out_valid && !out_ready;
      h_data = out_data;
      h_last = out_last;
      h_max  = out_max;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_beat: got data %0d want none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_last !== e.last || out_max !== e.max) begin
            failures++;
            $display("FAIL replay_beat %0d: got data=%0d last=%b max=%0d want data=%0d last=%b max=%0d",
                     got, out_data, out_last, out_max, e.data, e.last, e.max);
          end
        end
        got++;
        if (got == stop_after || got == n) break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (got != ((stop_after < n) ? stop_after : n)) begin
      failures++;
      $display("FAIL drain_timeout: got %0d beats want %0d", got, n);
    end
    if (stop_after >= n) begin
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || exp_q.size() != 0) begin
        failures++;
        $display("FAIL back_to_load: got in_ready=%b out_valid=%b pending=%0d want 1/0/0",
                 in_ready, out_valid, exp_q.size());
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_max !== '0 ||
        out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got rdy=%b vld=%b data=%0d max=%0d last=%b want 1 0 0 0 0",
               in_ready, out_valid, out_data, out_max, out_last);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lo;
    vec[0] = 3; vec[1] = -5; vec[2] = 7; vec[3] = 1;
    send_vector(4, 1'b1);
    drain(4, 1'b0, 1'b0, 99, lo);
    checks++;
    if (lo != 4) begin
      failures++;
      $display("FAIL in_ready_low_cycles: got %0d want 4", lo);
    end
    checks++;
    if (out_max !== 8'sd7) begin
      failures++;
      $display("FAIL max_held_after_replay: got %0d want 7", out_max);
    end
  endtask

  task automatic test_auto_close();
    int lo;
    for (int i = 0; i < VL; i++) vec[i] = i;
    send_vector(VL, 1'b0);
    drain(VL, 1'b0, 1'b0, 99, lo);
  endtask

  task automatic test_extremes();
    int lo;
    vec[0] = -128; vec[1] = 127;
    send_vector(2, 1'b1);
    drain(2, 1'b0, 1'b0, 99, lo);
  endtask

  task automatic test_back_to_back_stall();
    int lo;
    vec[0] = 5; vec[1] = 9; vec[2] = 2;
    send_vector(3, 1'b1);
    drain(3, 1'b1, 1'b1, 99, lo);
    vec[0] = -3; vec[1] = -3; vec[2] = -8; vec[3] = -1; vec[4] = -1;
    send_vector(5, 1'b1);
    drain(5, 1'b1, 1'b0, 99, lo);
  endtask

  task automatic test_single();
    int lo;
    vec[0] = -42;
    send_vector(1, 1'b1);
    drain(1, 1'b0, 1'b0, 99, lo);
    checks++;
    if (out_max !== -8'sd42) begin
      failures++;
      $display("FAIL single_max: got %0d want -42", out_max);
    end
  endtask

  task automatic test_reset_mid();
    int lo;
    vec[0] = 10; vec[1] = 20; vec[2] = 30;
    send_vector(3, 1'b1);
    drain(3, 1'b0, 1'b0, 1, lo);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_max !== '0) begin
      failures++;
      $display("FAIL reset_mid_replay: got vld=%b rdy=%b max=%0d want 0 1 0",
               out_valid, in_ready, out_max);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    vec[0] = 1; vec[1] = 2;
    send_vector(2, 1'b1);
    drain(2, 1'b0, 1'b0, 99, lo);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_auto_close();
    test_extremes();
    test_back_to_back_stall();
    test_single();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
